// File: rtl/sdf_delay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sdf_delay_buffer
// Description : Programmable-length complex sample delay for SDF FFT stages.
//               Delay counts accepted samples; output is masked to zero
//               until the circular buffer holds len_q valid samples.
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_delay_buffer #(
    parameter int DW      = 12,
    parameter int MAX_LEN = 256,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [DW-1:0] data_re_in,
    input  logic [DW-1:0] data_im_in,
    input  logic [LW-1:0] len_cfg,
    input  logic          flush,
    output logic          valid_out,
    output logic [DW-1:0] data_re_out,
    output logic [DW-1:0] data_im_out,
    output logic          primed,
    output logic          cfg_err
);

    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LW-1:0] c_MAX_LEN = LW'(MAX_LEN);
    localparam logic [LW-1:0] c_ONE     = LW'(1);

    logic [2*DW-1:0] r_mem [0:MAX_LEN-1];
    logic [2*DW-1:0] r_rd_data;

    logic [AW-1:0]   r_ptr;
    logic [LW-1:0]   r_fill;
    logic [LW-1:0]   r_len;
    logic            r_err;
    logic            r_valid;
    logic            r_real;
    logic            r_primed;

    logic            w_restart;
    logic            w_acc;
    logic [LW-1:0]   w_len;
    logic            w_err;
    logic [AW-1:0]   w_ptr_nxt;
    logic [LW-1:0]   w_fill_nxt;
    logic            w_full;

    assign w_restart = rst | flush;
    assign w_acc     = valid_in & ~w_restart;
    assign w_full    = (r_fill == r_len);

    always_comb begin
        w_len = len_cfg;
        w_err = 1'b0;
        if (len_cfg == '0) begin
            w_len = c_ONE;
            w_err = 1'b1;
        end else if (len_cfg > c_MAX_LEN) begin
            w_len = c_MAX_LEN;
            w_err = 1'b1;
        end
    end

    // The pointer never exceeds len_q-1 < MAX_LEN, so AW bits always suffice.
    assign w_ptr_nxt  = (LW'(r_ptr) == (r_len - c_ONE)) ? '0 : (r_ptr + AW'(1));
    assign w_fill_nxt = w_full ? r_fill : (r_fill + c_ONE);

    // Read-first RAM: the registered read returns the entry being overwritten.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_rd_data    <= r_mem[r_ptr];
            r_mem[r_ptr] <= {data_re_in, data_im_in};
        end
    end

    always_ff @(posedge clk) begin
        if (w_restart) begin
            r_ptr    <= '0;
            r_fill   <= '0;
            r_len    <= w_len;
            r_err    <= w_err;
            r_valid  <= 1'b0;
            r_real   <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_real   <= w_full;
                r_ptr    <= w_ptr_nxt;
                r_fill   <= w_fill_nxt;
                r_primed <= (w_fill_nxt == r_len);
            end
        end
    end

    // Stale RAM contents after reset/flush are hidden by the r_real mask.
    assign data_re_out = r_rd_data[2*DW-1:DW] & {DW{r_real}};
    assign data_im_out = r_rd_data[DW-1:0]    & {DW{r_real}};
    assign valid_out   = r_valid;
    assign primed      = r_primed;
    assign cfg_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdf_delay_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdf_delay_buffer
// Description : Directed self-checking bench for sdf_delay_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_delay_buffer;

    localparam int DW      = 12;
    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_re_in;
    logic [DW-1:0] data_im_in;
    logic [LW-1:0] len_cfg;
    logic          flush;
    logic          valid_out;
    logic [DW-1:0] data_re_out;
    logic [DW-1:0] data_im_out;
    logic          primed;
    logic          cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    sdf_delay_buffer #(
        .DW      (DW),
        .MAX_LEN (MAX_LEN)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_re_in  (data_re_in),
        .data_im_in  (data_im_in),
        .len_cfg     (len_cfg),
        .flush       (flush),
        .valid_out   (valid_out),
        .data_re_out (data_re_out),
        .data_im_out (data_im_out),
        .primed      (primed),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input int ere, input int eim);
        logic [DW-1:0] e_re;
        logic [DW-1:0] e_im;
        e_re = DW'(ere);
        e_im = DW'(eim);
        chk({tag, "_valid"}, 32'(valid_out), 32'(ev));
        chk({tag, "_re"}, 32'(data_re_out), 32'(e_re));
        chk({tag, "_im"}, 32'(data_im_out), 32'(e_im));
    endtask

    task automatic step(input logic v, input int re, input int im);
        valid_in   = v;
        data_re_in = DW'(re);
        data_im_in = DW'(im);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int len);
        rst      = 1'b1;
        len_cfg  = LW'(len);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        valid_in   = 1'b0;
        data_re_in = '0;
        data_im_in = '0;
        len_cfg    = '0;

        // Reset with L=4, continuous stream re=1..10, im=-1..-10
        do_reset(4);
        chk_out("rst", 1'b0, 0, 0);
        chk("rst_primed", 32'(primed), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, k, -k);
            chk_out("l4", 1'b1, (k > 4) ? k - 4 : 0, (k > 4) ? -(k - 4) : 0);
            chk("l4_primed", 32'(primed), 32'(k >= 4));
        end
        step(1'b0, 55, 55);
        chk_out("l4_bubble", 1'b0, 6, -6);

        // L=3 with two-cycle bubbles between samples
        do_reset(3);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 5 + k, 20 + k);
            chk_out("l3_acc", 1'b1, (k >= 3) ? 2 + k : 0, (k >= 3) ? 17 + k : 0);
            for (int b = 0; b < 2; b++) begin
                step(1'b0, 0, 0);
                chk_out("l3_hold", 1'b0, (k >= 3) ? 2 + k : 0, (k >= 3) ? 17 + k : 0);
            end
        end
        chk("l3_primed", 32'(primed), 32'd1);

        // len_cfg=0 -> delay 1, cfg_err
        do_reset(0);
        chk("zero_cfg_err", 32'(cfg_err), 32'd1);
        step(1'b1, 7, 3);
        chk_out("zero_s0", 1'b1, 0, 0);
        step(1'b1, 8, 4);
        chk_out("zero_s1", 1'b1, 7, 3);
        chk("zero_primed", 32'(primed), 32'd1);

        // len_cfg > MAX_LEN -> delay MAX_LEN, cfg_err
        do_reset(MAX_LEN + 5);
        chk("big_cfg_err", 32'(cfg_err), 32'd1);
        for (int k = 1; k <= MAX_LEN + 2; k++) begin
            step(1'b1, k, 2 * k);
            chk_out("big", 1'b1, (k > MAX_LEN) ? k - MAX_LEN : 0,
                    (k > MAX_LEN) ? 2 * (k - MAX_LEN) : 0);
        end

        // Stream 20 at L=8, then flush to L=2 with a sample in the flush cycle
        do_reset(8);
        chk("l8_cfg_err", 32'(cfg_err), 32'd0);
        for (int k = 1; k <= 20; k++) step(1'b1, k, 0);
        chk_out("l8_last", 1'b1, 12, 0);
        flush   = 1'b1;
        len_cfg = LW'(2);
        step(1'b1, 99, 99);
        flush = 1'b0;
        chk_out("flush", 1'b0, 0, 0);
        chk("flush_primed", 32'(primed), 32'd0);
        step(1'b1, 100, 1);
        chk_out("fl_s0", 1'b1, 0, 0);
        step(1'b1, 101, 2);
        chk_out("fl_s1", 1'b1, 0, 0);
        chk("fl_primed", 32'(primed), 32'd1);
        step(1'b1, 102, 3);
        chk_out("fl_s2", 1'b1, 100, 1);

        // Reset mid-stream with valid_in high
        step(1'b1, 103, 4);
        chk_out("pre_rst", 1'b1, 101, 2);
        rst = 1'b1;
        step(1'b1, 104, 5);
        rst = 1'b0;
        chk_out("mid_rst", 1'b0, 0, 0);
        chk("mid_rst_primed", 32'(primed), 32'd0);

        // L=MAX_LEN ramp over three buffer lengths: wrap-around exactness
        do_reset(MAX_LEN);
        chk("ramp_cfg_err", 32'(cfg_err), 32'd0);
        for (int k = 0; k < 3 * MAX_LEN; k++) begin
            step(1'b1, 3 * k + 1, 100 - k);
            chk_out("ramp", 1'b1, (k >= MAX_LEN) ? 3 * (k - MAX_LEN) + 1 : 0,
                    (k >= MAX_LEN) ? 100 - (k - MAX_LEN) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdf_delay_buffer.md
Name: sdf_delay_buffer

Overview:
- Programmable-length complex (re/im) sample delay for single-path delay-feedback (SDF) FFT stages.
- Delays by L accepted samples, not clock cycles; bubbles (valid_in low) do not advance the delay.
- L is runtime-configurable up to MAX_LEN, so one RTL instance serves every stage and FFT size.
- Circular buffer with fill tracking: output is zero until the buffer is primed, so contents need no reset.

Parameters:
DW, 12, bit width of each of the re and im components
MAX_LEN, 256, maximum delay in samples (buffer depth); ≥1
LW, $clog2(MAX_LEN+1), width of len_cfg (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_in  in  1  input sample strobe
data_re_in  in  DW  input real part
data_im_in  in  DW  input imaginary part
len_cfg  in  LW  requested delay L; sampled only at reset/flush
flush  in  1  synchronous restart: clears fill/pointer, relatches len_cfg
valid_out  out  1  output strobe
data_re_out  out  DW  delayed real part
data_im_out  out  DW  delayed imaginary part
primed  out  1  buffer holds L valid samples; output data is real
cfg_err  out  1  last latched len_cfg was illegal (0 or > MAX_LEN)

Behaviour:
- One clock; rst is synchronous, active-high.
- Reset values:
  - valid_out=0, data_re_out=0, data_im_out=0, primed=0.
  - Write pointer=0, fill count=0.
  - Active length len_q latched from len_cfg; cfg_err set per the legality rule below.
  - Buffer RAM is not cleared.
- Legality:
  - len_cfg==0 → len_q=1, cfg_err=1.
  - len_cfg>MAX_LEN → len_q=MAX_LEN, cfg_err=1.
  - Otherwise len_q=len_cfg, cfg_err=0.
  - cfg_err holds until the next reset/flush.
- len_cfg is ignored outside reset/flush cycles.
- Accept (valid_in=1, no rst, no flush):
  - Read the entry at ptr, then write the new sample at ptr in the same cycle (read-before-write).
  - ptr advances ptr→ptr+1, wrapping to 0 when ptr==len_q-1.
  - fill increments, saturating at len_q.
- Output timing:
  - valid_out equals valid_in registered one cycle (cleared on rst/flush).
  - Outputs are registered, latency 1 cycle.
- Data rule: for the k-th accepted sample (k from 0 after reset/flush):
  - k<len_q → data_out is 0.
  - k≥len_q → data_out is sample k-len_q.
  - Decision uses fill before increment (fill==len_q means real data).
- primed=1 registered when fill==len_q. Rises in the cycle after the len_q-th accept; drops on rst/flush.
- data_*_out holds its last value when valid_out=0. No change on bubbles.
- Flush (priority rst > flush > valid_in):
  - Same effect as reset on ptr, fill, len_q, cfg_err, primed, valid_out.
  - Data outputs are zeroed.
  - A sample presented in the flush cycle is dropped.
- Mid-stream flush or reset: previously stored samples never appear at the output. They are masked by fill.
- MAX_LEN=1 and len_q=1 are legal: output is the previous accepted sample.
- Arithmetic: data is passed through bit-exact, no sign handling. Pointer and fill are LW bits wide.
- Implementation:
  - Buffer is inferred as simple dual-port or single-port RAM.
  - The read-during-write result must be the OLD data. Achieve this with a registered read or an explicit read-first style.

Test Plan:
- rst with len_cfg=4, then valid_in continuous with re=1..10, im=-1..-10:
  - valid_out trails valid_in by 1 cycle.
  - Outputs are 0 for the first 4 samples, then re=1..6 and im=-1..-6.
  - primed rises the cycle after the 4th accept.
- len_cfg=3, inputs 5,6,7,8,9 with 2-cycle bubbles between each:
  - Outputs 0,0,0,5,6, each 1 cycle after its input.
  - Data holds during bubbles.
- len_cfg=0 at reset → cfg_err=1, delay=1 (input 7,8 → output 0,7).
- len_cfg=MAX_LEN+5 → cfg_err=1, delay=MAX_LEN.
- Stream 20 samples with len=8, then flush with len_cfg=2 and valid_in=1 in the flush cycle:
  - Flushed sample is dropped; valid_out=0 next cycle; primed=0.
  - Next inputs 100,101,102 → outputs 0,0,100 (no stale data).
- Reset asserted mid-stream with valid_in=1 → next cycle all outputs 0.
- len_cfg=MAX_LEN, 3·MAX_LEN accepted ramp samples → wrap-around exact: output k = input k-MAX_LEN.
